if_fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register. It consumes the ID-stage branch decision (`Branch`, `JumpAmount`, produced on the falling clock edge) and the decoder's jump request. On a redirect it loads the new PC and squashes the wrong-path instruction. It also keeps a saturating count of taken redirects for performance debug.

---
 rtl/if_fetch_unit.sv | 87 ++++++++
 tb/tb_if_fetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and holds the IF/ID register.
// Taken branches and jumps from ID redirect the PC and squash the wrong-path fetch.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        Branch,
    input  logic [15:0] JumpAmount,
    input  logic        Jump,
    input  logic [25:0] JumpTarget,
    input  logic [31:0] IMemInstr,
    output logic [31:0] PC,
    output logic [31:0] IFID_Instruction,
    output logic [31:0] IFID_PCPlus4,
    output logic        IFID_Valid,
    output logic [15:0] RedirectCount
);

    typedef enum logic {RUN, SQUASH} state_t;

    state_t             state, state_nxt;
    logic               redirect;
    logic signed [15:0] jump_amt;
    logic signed [31:0] br_off;
    logic [31:0]        pc_seq, br_target, j_target, pc_nxt;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_comb begin
        jump_amt  = JumpAmount;
        br_off    = {{14{jump_amt[15]}}, jump_amt, 2'b00};
        pc_seq    = PC + 32'd4;
        br_target = IFID_PCPlus4 + $unsigned(br_off);
        j_target  = {IFID_PCPlus4[31:28], JumpTarget, 2'b00};
    end

    // A flushed slot (Valid=0) or the SQUASH cycle can never redirect; Branch outranks Jump.
    always_comb begin
        state_nxt = state;
        redirect  = 1'b0;
        pc_nxt    = pc_seq;
        if (!Stall) begin
            if (state == SQUASH) begin
                state_nxt = RUN;
            end else if (IFID_Valid && (Branch || Jump)) begin
                redirect  = 1'b1;
                state_nxt = SQUASH;
                pc_nxt    = Branch ? br_target : j_target;
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            PC               <= RESET_PC;
            IFID_Instruction <= 32'h0;
            IFID_PCPlus4     <= 32'h0;
            IFID_Valid       <= 1'b0;
            RedirectCount    <= 16'h0;
        end else if (!Stall) begin
            PC <= pc_nxt;
            if (redirect) begin
                IFID_Instruction <= 32'h0;
                IFID_PCPlus4     <= 32'h0;
                IFID_Valid       <= 1'b0;
                RedirectCount    <= sat_inc(RedirectCount);
            end else begin
                IFID_Instruction <= IMemInstr;
                IFID_PCPlus4     <= pc_seq;
                IFID_Valid       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: two instances (reset PC 0 and 0x4000_000C) share all stimulus.
// Instruction memory returns 0x2000_0000 + address for each instance.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic [15:0] jump_amount = 16'h0;
    logic        jump = 1'b0;
    logic [25:0] jump_target = 26'h0;

    logic [31:0] imem_a, pc_a, instr_a, pcp4_a;
    logic        valid_a;
    logic [15:0] cnt_a;
    logic [31:0] imem_b, pc_b, instr_b, pcp4_b;
    logic        valid_b;
    logic [15:0] cnt_b;

    int errors = 0;
    int checks = 0;

    assign imem_a = 32'h2000_0000 + pc_a;
    assign imem_b = 32'h2000_0000 + pc_b;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut_a (
        .Clk(clk), .Rst(rst_n), .Stall(stall), .Branch(branch), .JumpAmount(jump_amount),
        .Jump(jump), .JumpTarget(jump_target), .IMemInstr(imem_a), .PC(pc_a),
        .IFID_Instruction(instr_a), .IFID_PCPlus4(pcp4_a), .IFID_Valid(valid_a),
        .RedirectCount(cnt_a)
    );

    if_fetch_unit #(.RESET_PC(32'h4000_000C)) dut_b (
        .Clk(clk), .Rst(rst_n), .Stall(stall), .Branch(branch), .JumpAmount(jump_amount),
        .Jump(jump), .JumpTarget(jump_target), .IMemInstr(imem_b), .PC(pc_b),
        .IFID_Instruction(instr_b), .IFID_PCPlus4(pcp4_b), .IFID_Valid(valid_b),
        .RedirectCount(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // ---------------- reset, then jump tests on dut_b
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc_a",    pc_a, 32'h0);
        chk("rst_instr_a", instr_a, 32'h0);
        chk("rst_pcp4_a",  pcp4_a, 32'h0);
        chk("rst_valid_a", {31'h0, valid_a}, 32'h0);
        chk("rst_cnt_a",   {16'h0, cnt_a}, 32'h0);
        chk("rst_pc_b",    pc_b, 32'h4000_000C);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("b_first_pc",    pc_b, 32'h4000_0010);
        chk("b_first_instr", instr_b, 32'h6000_000C);
        chk("b_first_pcp4",  pcp4_b, 32'h4000_0010);
        chk("b_first_valid", {31'h0, valid_b}, 32'h1);
        jump = 1'b1;
        jump_target = 26'h000_0100;
        tick(1);
        chk("jump_pc",    pc_b, 32'h4000_0400);
        chk("jump_valid", {31'h0, valid_b}, 32'h0);
        chk("jump_cnt",   {16'h0, cnt_b}, 32'h1);
        jump = 1'b0;
        tick(1);
        chk("jump_tgt_instr", instr_b, 32'h6000_0400);
        chk("jump_tgt_pcp4",  pcp4_b, 32'h4000_0404);
        chk("jump_tgt_valid", {31'h0, valid_b}, 32'h1);
        chk("jump_cnt_hold",  {16'h0, cnt_b}, 32'h1);

        // branch and jump together: branch wins, counted once
        rst_n = 1'b0;
        #1 chk("rst2_cnt_b", {16'h0, cnt_b}, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        chk("bj_pre_pcp4", pcp4_b, 32'h4000_0010);
        jump = 1'b1;
        branch = 1'b1;
        jump_amount = 16'h0002;
        tick(1);
        chk("bj_pc",  pc_b, 32'h4000_0018);
        chk("bj_cnt", {16'h0, cnt_b}, 32'h1);
        jump = 1'b0;
        branch = 1'b0;
        tick(1);
        chk("bj_cnt_once", {16'h0, cnt_b}, 32'h1);

        // ---------------- sequential fetch on dut_a
        #2 rst_n = 1'b0;
        #1 chk("rst3_pc_a", pc_a, 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(3);
        chk("seq_pc",    pc_a, 32'h0000_000C);
        chk("seq_instr", instr_a, 32'h2000_0008);
        chk("seq_pcp4",  pcp4_a, 32'h0000_000C);
        chk("seq_valid", {31'h0, valid_a}, 32'h1);
        tick(13);
        chk("pre_br_pcp4", pcp4_a, 32'h0000_0040);

        // backward branch
        branch = 1'b1;
        jump_amount = 16'hFFFC;
        tick(1);
        chk("bbr_pc",    pc_a, 32'h0000_0030);
        chk("bbr_valid", {31'h0, valid_a}, 32'h0);
        chk("bbr_instr", instr_a, 32'h0);
        chk("bbr_cnt",   {16'h0, cnt_a}, 32'h1);
        branch = 1'b0;
        tick(1);
        chk("bbr_tgt_instr", instr_a, 32'h2000_0030);
        chk("bbr_tgt_pcp4",  pcp4_a, 32'h0000_0034);
        chk("bbr_tgt_valid", {31'h0, valid_a}, 32'h1);
        chk("bbr_tgt_pc",    pc_a, 32'h0000_0034);

        // stall holding a taken branch
        stall = 1'b1;
        branch = 1'b1;
        jump_amount = 16'h0001;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("stall_pc",    pc_a, 32'h0000_0034);
            chk("stall_instr", instr_a, 32'h2000_0030);
            chk("stall_pcp4",  pcp4_a, 32'h0000_0034);
            chk("stall_cnt",   {16'h0, cnt_a}, 32'h1);
        end
        stall = 1'b0;
        tick(1);
        chk("unstall_pc",    pc_a, 32'h0000_0038);
        chk("unstall_valid", {31'h0, valid_a}, 32'h0);
        chk("unstall_cnt",   {16'h0, cnt_a}, 32'h2);
        tick(1);
        chk("squash_pc",    pc_a, 32'h0000_003C);
        chk("squash_instr", instr_a, 32'h2000_0038);
        chk("squash_valid", {31'h0, valid_a}, 32'h1);
        chk("squash_cnt",   {16'h0, cnt_a}, 32'h2);

        // async reset during SQUASH
        jump_amount = 16'h0010;
        tick(1);
        chk("mid_pc",  pc_a, 32'h0000_007C);
        chk("mid_cnt", {16'h0, cnt_a}, 32'h3);
        branch = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pc",    pc_a, 32'h0);
        chk("arst_instr", instr_a, 32'h0);
        chk("arst_pcp4",  pcp4_a, 32'h0);
        chk("arst_valid", {31'h0, valid_a}, 32'h0);
        chk("arst_cnt",   {16'h0, cnt_a}, 32'h0);
        #1 rst_n = 1'b1;
        tick(1);
        chk("resume_pc",    pc_a, 32'h0000_0004);
        chk("resume_instr", instr_a, 32'h2000_0000);
        chk("resume_valid", {31'h0, valid_a}, 32'h1);

        // most negative offset, then forward to the top of memory and wrap
        branch = 1'b1;
        jump_amount = 16'h8000;
        tick(1);
        chk("neg_pc", pc_a, 32'hFFFE_0004);
        branch = 1'b0;
        tick(1);
        chk("neg_tgt_pcp4", pcp4_a, 32'hFFFE_0008);
        branch = 1'b1;
        jump_amount = 16'h7FFD;
        tick(1);
        chk("top_pc",  pc_a, 32'hFFFF_FFFC);
        chk("top_cnt", {16'h0, cnt_a}, 32'h2);
        branch = 1'b0;
        tick(1);
        chk("wrap_pc",    pc_a, 32'h0000_0000);
        chk("wrap_pcp4",  pcp4_a, 32'h0000_0000);
        chk("wrap_instr", instr_a, 32'h1FFF_FFFC);
        chk("wrap_valid", {31'h0, valid_a}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
